// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch program-counter unit: branch encodings,
// default redirect addresses and the branch-condition evaluator.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    localparam int          DEF_ADDR_W    = 30;
    localparam logic [29:0] DEF_RESET_PC  = 30'h0000_0C00;
    localparam logic [29:0] DEF_EXC_PC    = 30'h0000_1060;
    localparam int          DEF_RAS_DEPTH = 4;

    // zero/neg describe the ALU result of the compare already performed in execute.
    function automatic logic branch_taken(input logic [2:0] br_type,
                                          input logic zero,
                                          input logic neg);
        logic taken;
        case (br_type_e'(br_type))
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLEZ: taken = neg | zero;
            BR_BGTZ: taken = ~neg & ~zero;
            BR_BLTZ: taken = neg;
            BR_BGEZ: taken = ~neg;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular buffer that overwrites the oldest entry when
// full, and flags a miss when a pop finds it empty or finds the wrong address.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              miss
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              miss_q, miss_d;

    // wptr points at the next free slot; the newest entry sits just below it.
    assign top_idx = (wptr_q == '0) ? PTR_W'(DEPTH - 1) : wptr_q - PTR_W'(1);
    assign empty   = (cnt_q == '0);
    assign top     = empty ? '0 : mem_q[top_idx];
    assign miss    = miss_q;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        miss_d = 1'b0;
        if (push) begin
            mem_d[wptr_q] = push_addr;
            wptr_d        = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                miss_d = 1'b1;
            end else begin
                miss_d = (mem_q[top_idx] != cmp_addr);
                wptr_d = top_idx;
                cnt_d  = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            cnt_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end

    // Entry storage needs no reset: an empty count masks stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: selects the next word address from flush, stall,
// register jump, absolute jump, conditional branch or sequential fetch.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_PC    = ADDR_W'(DEF_EXC_PC),
    parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        br_type,
    input  logic              zero,
    input  logic              neg,
    input  logic [15:0]       imm,
    input  logic              j_en,
    input  logic              jal,
    input  logic [25:0]       tar_addr,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_miss
);

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic signed [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0]        br_tgt, j_tgt;
    logic                     ras_push, ras_pop;

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign imm_ext  = {{(ADDR_W - 16){imm[15]}}, imm};
    assign br_tgt   = pc_plus1 + $unsigned(imm_ext);
    assign j_tgt    = {pc_q[ADDR_W-1:26], tar_addr};

    // A JR in the same cycle as a J/JAL wins, so the link push is suppressed.
    assign ras_pop  = jr_en & ~stall & ~flush;
    assign ras_push = j_en & jal & ~jr_en & ~stall & ~flush;

    always_comb begin
        pc_d = pc_plus1;
        if (flush) begin
            pc_d = EXC_PC;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (jr_en) begin
            pc_d = jr_addr;
        end else if (j_en) begin
            pc_d = j_tgt;
        end else if (branch_taken(br_type, zero, neg)) begin
            pc_d = br_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (pc_plus1),
        .cmp_addr  (jr_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .miss      (ras_miss)
    );

endmodule
